// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared state encoding and default sizing for the divider arbiter.
package div_arb_pkg;
    localparam int DEF_W = 4;
    localparam int DEF_N = 4;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/div_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, search starts at ptr and wraps.
module rr_arbiter
    import div_arb_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    logic [PW-1:0] k;
    always_comb begin
        gnt = '0;
        k   = '0;
        for (int i = 0; i < N; i++) begin
            k = PW'((int'(ptr) + i) % N);
            if (gnt == '0 && req[k]) gnt[k] = 1'b1;
        end
    end
endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: shares one divider among N requesters, one request in flight at a time.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_dvnd,
    input  logic [N*W-1:0] req_dvsr,
    output logic [N-1:0]   req_ack,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_quo,
    output logic [W-1:0]   rsp_rmd,
    output logic           rsp_dz,
    output logic           busy,
    output logic           div_start,
    output logic [W-1:0]   div_dvnd,
    output logic [W-1:0]   div_dvsr,
    input  logic           div_ready,
    input  logic           div_done,
    input  logic [W-1:0]   div_quo,
    input  logic [W-1:0]   div_rmd
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    state_t        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d, idx_q, idx_d, gnt_idx;
    logic [N-1:0]  gnt;
    logic [W-1:0]  dvnd_q, dvnd_d, dvsr_q, dvsr_d, quo_q, quo_d, rmd_q, rmd_d;
    logic [W-1:0]  sel_dvnd, sel_dvsr;
    logic          dz_q, dz_d;
    rr_arbiter #(.N(N), .PW(PW)) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );
    always_comb begin
        gnt_idx  = '0;
        sel_dvnd = '0;
        sel_dvsr = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_idx  = PW'(i);
                sel_dvnd = req_dvnd[i*W +: W];
                sel_dvsr = req_dvsr[i*W +: W];
            end
        end
    end
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        dvnd_d    = dvnd_q;
        dvsr_d    = dvsr_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        dz_d      = dz_q;
        req_ack   = '0;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst && |req_valid) begin
                    req_ack = gnt;
                    idx_d   = gnt_idx;
                    ptr_d   = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
                    dvnd_d  = sel_dvnd;
                    dvsr_d  = sel_dvsr;
                    state_d = (sel_dvsr == '0) ? RESP : ISSUE;
                    // Divide-by-zero is answered locally; the divider is never started.
                    if (sel_dvsr == '0) begin
                        quo_d = '1;
                        rmd_d = sel_dvnd;
                        dz_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                div_start = div_ready && !rst;
                state_d   = div_ready ? WAIT : ISSUE;
            end
            WAIT: begin
                if (div_done) begin
                    quo_d   = div_quo;
                    rmd_d   = div_rmd;
                    dz_d    = 1'b0;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            dvnd_q  <= '0;
            dvsr_q  <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            dvnd_q  <= dvnd_d;
            dvsr_q  <= dvsr_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dz_q    <= dz_d;
        end
    end
    assign busy      = state_q != IDLE;
    assign rsp_valid = (state_q == RESP) ? N'(1) << idx_q : '0;
    assign rsp_quo   = quo_q;
    assign rsp_rmd   = rmd_q;
    assign rsp_dz    = dz_q;
    assign div_dvnd  = (state_q == ISSUE || state_q == WAIT) ? dvnd_q : '0;
    assign div_dvsr  = (state_q == ISSUE || state_q == WAIT) ? dvsr_q : '0;
endmodule
